// File: rtl/gap_broadcast.sv
// gap_broadcast: loads a CH-element channel vector, then streams it as an H_OUT x W_OUT x CH map in HWC order.
module gap_broadcast #(
  parameter int H_OUT = 8,
  parameter int W_OUT = 8,
  parameter int CH    = 56,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);
  localparam int HW = H_OUT > 1 ? $clog2(H_OUT) : 1;
  localparam int WW = W_OUT > 1 ? $clog2(W_OUT) : 1;
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  typedef enum logic {LOAD, EMIT} state_t;
  state_t state_q;
  logic signed [DW-1:0] vec_mem [CH];
  logic [CW-1:0] ld_cnt_q, c_q, c_d;
  logic [WW-1:0] w_q, w_d;
  logic [HW-1:0] h_q, h_d;
  logic in_ready_q, out_valid_q, out_last_q, busy_q;
  logic signed [DW-1:0] out_data_q;
  logic c_end, w_end, h_end, last_d, accept, fire;
  always_comb begin
    c_end  = c_q == CW'(CH - 1);
    w_end  = w_q == WW'(W_OUT - 1);
    h_end  = h_q == HW'(H_OUT - 1);
    c_d    = c_end ? '0 : c_q + 1'b1;
    w_d    = c_end ? (w_end ? '0 : w_q + 1'b1) : w_q;
    h_d    = (c_end && w_end) ? (h_end ? '0 : h_q + 1'b1) : h_q;
    last_d = (h_d == HW'(H_OUT - 1)) && (w_d == WW'(W_OUT - 1)) && (c_d == CW'(CH - 1));
    accept = in_valid && in_ready_q;
    fire   = out_valid_q && out_ready;
  end
  always_ff @(posedge clk)
    if (!rst && accept) vec_mem[ld_cnt_q] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ld_cnt_q    <= '0;
      h_q         <= '0;
      w_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else if (state_q == LOAD) begin
      in_ready_q <= 1'b1;
      if (accept) begin
        if (ld_cnt_q == CW'(CH - 1)) begin
          ld_cnt_q    <= '0;
          state_q     <= EMIT;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
          // channel 0 is still being written when the vector is one element long
          out_data_q  <= (ld_cnt_q == '0) ? in_data : vec_mem[0];
          out_last_q  <= (H_OUT == 1) && (W_OUT == 1) && (CH == 1);
          busy_q      <= 1'b1;
        end else begin
          ld_cnt_q <= ld_cnt_q + 1'b1;
        end
      end
    end else if (fire) begin
      h_q        <= h_d;
      w_q        <= w_d;
      c_q        <= c_d;
      out_data_q <= vec_mem[c_d];
      out_last_q <= last_d;
      if (out_last_q) begin
        state_q     <= LOAD;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        in_ready_q  <= 1'b1;
        busy_q      <= 1'b0;
      end
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
endmodule

// File: doc/gap_broadcast.md
Name: gap_broadcast

Overview:
- Inverse of the global-average-pool stage: takes one CH-element per-channel vector and re-expands it over an H_OUT x W_OUT spatial grid.
- Emits a full feature map in HWC order with every pixel of channel c equal to vec[c].
- Sits after the pooled-vector path as the channel-broadcast feeder for channel-scaling or unpool layers.
- Vector ingress and map egress both use valid/ready streaming.

Parameters:
- H_OUT, 8, output map height (>=1)
- W_OUT, 8, output map width (>=1)
- CH, 56, channels = vector length (>=1)
- DW, 32, signed data width of vector elements and output words

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  vector element offered
- in_ready  out  1  block accepts a vector element
- in_data  in  DW  signed vector element; channel order 0..CH-1
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output word
- out_data  out  DW  signed output word
- out_last  out  1  marks final word of the map
- busy  out  1  high while in EMIT state

Behaviour:
- State machine has two states, LOAD and EMIT.
- Storage: vec_mem[0:CH-1] of DW bits; load counter ld_cnt is 0..CH-1; emit counters h (0..H_OUT-1), w (0..W_OUT-1), c (0..CH-1).
- Reset (rst=1 at a clk edge):
  - state=LOAD; all counters 0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - vec_mem is not cleared.
  - in_ready is registered and rises on the first clock edge with rst=0.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: vec_mem[ld_cnt]<=in_data and ld_cnt increments.
  - On the accept with ld_cnt==CH-1: ld_cnt<=0, state<=EMIT, in_ready<=0.
  - At the same edge out_valid<=1, out_data<=vec_mem-equivalent of channel 0. This must be the value being written when CH==1, i.e. bypass the write.
  - Latency: first output word is valid the cycle after the last input accept.
- EMIT:
  - in_ready=0; in_data is ignored.
  - out_valid=1 and out_data=vec_mem[c] for the current (h,w,c).
  - On out_valid&&out_ready, counters advance with c fastest: c wraps CH-1->0 and increments w; w wraps W_OUT-1->0 and increments h.
  - out_data is registered and updated to the next channel's value on each handshake.
  - Stall (out_valid && !out_ready): out_data, out_last and all counters hold stable. No word may be dropped or duplicated.
  - out_last=1 exactly when (h,w,c)==(H_OUT-1,W_OUT-1,CH-1).
  - On the handshake of the out_last word: counters<=0, out_valid<=0, out_last<=0, state<=LOAD, in_ready<=1 on the same edge. Zero bubble cycles before the next vector can be accepted.
- busy=1 in EMIT, 0 otherwise.
- Total output words per vector = H_OUT*W_OUT*CH.
- With out_ready held high, EMIT lasts exactly H_OUT*W_OUT*CH cycles.
- Arithmetic: no arithmetic on data; words pass bit-exact and signedness is preserved. Counter widths are $clog2 of their range, minimum 1 bit.
- Reset mid-operation (LOAD partial or EMIT partial): the operation is abandoned.
  - Reset values apply on that edge; no further out_valid until a new full vector is loaded.
  - The partial vector is discarded (ld_cnt=0).
- in_valid during EMIT: not accepted (in_ready=0); upstream must hold it.
- out_ready during LOAD: ignored.

Test Plan:
- Basic broadcast:
  - Stimulus: H_OUT=W_OUT=2, CH=3; load 5,-7,0x7FFFFFFF; out_ready=1.
  - Required: 12 words 5,-7,0x7FFFFFFF repeating ×4; out_last only on word 12; in_ready=1 the cycle after.
- Backpressure:
  - Stimulus: same config, out_ready toggled 1,0,0,1,...
  - Required: out_data/out_last stable through each stall; exact 12-word sequence; no duplicates.
- Latency/throughput:
  - Stimulus: default params, last input accepted at cycle T.
  - Required: out_valid=1 at T+1; out_last handshake at T+3584; in_ready=1 at T+3585.
- Back-to-back vectors with gapped in_valid:
  - Stimulus: second vector 1..56 loaded with in_valid bubbles.
  - Required: second map uses only new values; ld_cnt is not corrupted by bubbles.
- Reset mid-EMIT:
  - Stimulus: assert rst at word 100.
  - Required: next cycle out_valid=0, busy=0, in_ready=0, then in_ready=1. A fresh 56-element load restarts at (0,0,0).
- CH=1 corner:
  - Stimulus: CH=1, H_OUT=W_OUT=1, load -1.
  - Required: single word -1 with out_last=1 the cycle after the accept.
